wb_master_engine: RTL and testbench



---
 rtl/wb_master_engine_pkg.sv | 23 ++
 rtl/wb_master_engine_if.sv | 31 +++
 rtl/wb_master_engine_wdt.sv | 50 +++++
 rtl/wb_master_engine.sv | 165 ++++++++++++++++
 tb/tb_wb_master_engine.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_engine_pkg.sv
// Shared types and bus widths for the Wishbone initiator.
package wb_master_pkg;

  localparam int WB_ADR_W = 64;
  localparam int WB_DAT_W = 64;
  localparam int WB_SEL_W = 8;
  localparam int WB_TAG_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2,
    RESP    = 2'd3
  } wb_mst_state_e;

  typedef enum logic [1:0] {
    OKAY            = 2'd0,
    ERR             = 2'd1,
    RETRY_EXHAUSTED = 2'd2,
    TIMEOUT         = 2'd3
  } wb_rsp_status_e;

endpackage

// File: rtl/wb_master_engine_if.sv
// Wishbone B4 classic-cycle signal bundle between one initiator and the interconnect.
interface wb_master_engine_if;
  import wb_master_pkg::*;

  logic                CYC_O;
  logic                STB_O;
  logic                WE_O;
  logic                LOCK_O;
  logic [WB_ADR_W-1:0] ADR_O;
  logic [WB_DAT_W-1:0] DAT_O;
  logic [WB_SEL_W-1:0] SEL_O;
  logic [WB_TAG_W-1:0] TGA_O;
  logic [WB_TAG_W-1:0] TGC_O;
  logic [WB_TAG_W-1:0] TGD_O;
  logic [WB_DAT_W-1:0] DAT_I;
  logic [WB_TAG_W-1:0] TGD_I;
  logic                ACK_I;
  logic                ERR_I;
  logic                RTY_I;

  modport master (
    output CYC_O, STB_O, WE_O, LOCK_O, ADR_O, DAT_O, SEL_O, TGA_O, TGC_O, TGD_O,
    input  DAT_I, TGD_I, ACK_I, ERR_I, RTY_I
  );

  modport slave (
    input  CYC_O, STB_O, WE_O, LOCK_O, ADR_O, DAT_O, SEL_O, TGA_O, TGC_O, TGD_O,
    output DAT_I, TGD_I, ACK_I, ERR_I, RTY_I
  );

endinterface

// File: rtl/wb_master_engine_wdt.sv
// Wait-state and retry counters for one command; both restart on every accepted command.
module wb_master_wdt #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic tick_i,
  input  logic retry_i,
  output logic timeout_hit_o,
  output logic retry_exhausted_o
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam int RTY_W  = $clog2(MAX_RETRY) + 1;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RTY_W-1:0]  retry_cnt_q, retry_cnt_d;

  // A retry starts a fresh wait window; clear restarts both counts.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    retry_cnt_d = retry_cnt_q;
    if (clear_i) begin
      wait_cnt_d  = '0;
      retry_cnt_d = '0;
    end else if (retry_i) begin
      wait_cnt_d  = '0;
      retry_cnt_d = retry_cnt_q + RTY_W'(1);
    end else if (tick_i) begin
      wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign timeout_hit_o     = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
  assign retry_exhausted_o = (retry_cnt_q == RTY_W'(MAX_RETRY));

endmodule

// File: rtl/wb_master_engine.sv
// Single-outstanding Wishbone classic initiator with bounded retry and wait-state timeout.
module wb_master_engine
  import wb_master_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  input  logic [WB_TAG_W-1:0] cmd_tga,
  input  logic [WB_TAG_W-1:0] cmd_tgc,
  input  logic [WB_TAG_W-1:0] cmd_tgd,
  input  logic                cmd_lock,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic [WB_TAG_W-1:0] rsp_tgd,
  output logic [1:0]          rsp_status,
  wb_master_engine_if.master  wb
);

  wb_mst_state_e       state_q;
  logic                cmd_ready_q, rsp_valid_q;
  logic                cyc_q, stb_q, we_q, lock_q;
  logic [WB_ADR_W-1:0] adr_q;
  logic [WB_DAT_W-1:0] dat_q, rsp_dat_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic [WB_TAG_W-1:0] tga_q, tgc_q, tgd_q, rsp_tgd_q;
  wb_rsp_status_e      rsp_status_q, rsp_status_d;

  logic accept, in_bus, any_term, term_err, term_rty, term_ack;
  logic timeout_hit, retry_exhausted, bus_done;

  assign accept   = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign in_bus   = (state_q == BUS);
  assign any_term = wb.ERR_I || wb.RTY_I || wb.ACK_I;
  assign term_err = wb.ERR_I;
  assign term_rty = wb.RTY_I && !wb.ERR_I;
  assign term_ack = wb.ACK_I && !wb.RTY_I && !wb.ERR_I;
  // A termination on the last wait cycle wins over the timeout.
  assign bus_done = term_err || term_ack || (term_rty && retry_exhausted) ||
                    (!any_term && timeout_hit);

  wb_master_wdt #(
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT)
  ) u_wdt (
    .clk               (clk),
    .rst               (rst),
    .clear_i           (accept),
    .tick_i            (in_bus && !any_term && !timeout_hit),
    .retry_i           (in_bus && term_rty && !retry_exhausted),
    .timeout_hit_o     (timeout_hit),
    .retry_exhausted_o (retry_exhausted)
  );

  // Status reported when the current bus attempt ends the command.
  always_comb begin
    rsp_status_d = OKAY;
    if (term_err)      rsp_status_d = ERR;
    else if (term_rty) rsp_status_d = RETRY_EXHAUSTED;
    else if (term_ack) rsp_status_d = OKAY;
    else               rsp_status_d = wb_master_pkg::TIMEOUT;
  end

  // Command capture, bus-cycle sequencing and response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      lock_q       <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      tga_q        <= '0;
      tgc_q        <= '0;
      tgd_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_tgd_q    <= '0;
      rsp_status_q <= OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q  <= 1'b0;
            cyc_q        <= 1'b1;
            stb_q        <= 1'b1;
            lock_q       <= cmd_lock;
            we_q         <= cmd_we;
            adr_q        <= cmd_adr;
            dat_q        <= cmd_dat;
            sel_q        <= cmd_sel;
            tga_q        <= cmd_tga;
            tgc_q        <= cmd_tgc;
            tgd_q        <= cmd_tgd;
            rsp_dat_q    <= '0;
            rsp_tgd_q    <= '0;
            rsp_status_q <= OKAY;
            state_q      <= BUS;
          end
        end
        BUS: begin
          if (bus_done) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            lock_q       <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= rsp_status_d;
            if (term_ack) begin
              if (!we_q) rsp_dat_q <= wb.DAT_I;
              rsp_tgd_q <= wb.TGD_I;
            end
            state_q <= RESP;
          end else if (term_rty) begin
            stb_q   <= 1'b0;
            cyc_q   <= lock_q;
            state_q <= BACKOFF;
          end
        end
        BACKOFF: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          state_q <= BUS;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dat    = rsp_dat_q;
  assign rsp_tgd    = rsp_tgd_q;
  assign rsp_status = rsp_status_q;

  assign wb.CYC_O  = cyc_q;
  assign wb.STB_O  = stb_q;
  assign wb.WE_O   = we_q;
  assign wb.LOCK_O = lock_q;
  assign wb.ADR_O  = adr_q;
  assign wb.DAT_O  = dat_q;
  assign wb.SEL_O  = sel_q;
  assign wb.TGA_O  = tga_q;
  assign wb.TGC_O  = tgc_q;
  assign wb.TGD_O  = tgd_q;

endmodule

// File: tb/tb_wb_master_engine.sv
// Bench for wb_master_engine: scripted/random slave behaviour against a per-command outcome model.
module tb_wb_master_engine;

  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 16;
  // slave behaviour for one bus attempt
  localparam int T_SIL = 0, T_ACK = 1, T_ERR = 2, T_RTY = 3, T_ALL = 4, T_RA = 5;

  typedef struct {
    int          waits;
    int          term;
    logic [63:0] dat;
    logic [15:0] tgd;
  } att_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0, cmd_lock = 1'b0;
  logic [63:0] cmd_adr = '0, cmd_dat = '0;
  logic [7:0]  cmd_sel = '0;
  logic [15:0] cmd_tga = '0, cmd_tgc = '0, cmd_tgd = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [63:0] rsp_dat;
  logic [15:0] rsp_tgd;
  logic [1:0]  rsp_status;

  wb_master_engine_if wb ();

  wb_master_engine #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .cmd_tga(cmd_tga), .cmd_tgc(cmd_tgc), .cmd_tgd(cmd_tgd), .cmd_lock(cmd_lock),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_tgd(rsp_tgd), .rsp_status(rsp_status),
    .wb(wb)
  );

  always #5 clk = ~clk;

  att_t  script[$];
  att_t  cur;
  int    wcnt;
  bit    prev_stb = 1'b0;
  int    stb_cnt, att_cnt, gap_cnt, bus_bad;
  int    n_tests = 0, n_fail = 0;
  string cur_case = "reset";

  logic        e_we, e_lock;
  logic [63:0] e_adr, e_dat;
  logic [7:0]  e_sel;
  logic [15:0] e_tga, e_tgc, e_tgd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_case, tag, obs, exp);
    end
  endtask

  // Slave model and bus monitor, updated on the falling edge.
  always @(negedge clk) begin
    wb.ACK_I = 1'b0;
    wb.ERR_I = 1'b0;
    wb.RTY_I = 1'b0;
    wb.DAT_I = {$urandom, $urandom};
    wb.TGD_I = 16'($urandom);
    if (wb.STB_O) begin
      stb_cnt++;
      if (!prev_stb) begin
        att_cnt++;
        wcnt = 0;
        if (script.size() > 0) cur = script.pop_front();
        else                   cur = '{0, T_SIL, 64'd0, 16'd0};
      end
      if (!wb.CYC_O || wb.WE_O !== e_we || wb.LOCK_O !== e_lock || wb.ADR_O !== e_adr ||
          wb.DAT_O !== e_dat || wb.SEL_O !== e_sel || wb.TGA_O !== e_tga ||
          wb.TGC_O !== e_tgc || wb.TGD_O !== e_tgd)
        bus_bad++;
      if (cur.term != T_SIL && wcnt == cur.waits) begin
        wb.ERR_I = (cur.term == T_ERR || cur.term == T_ALL);
        wb.RTY_I = (cur.term == T_RTY || cur.term == T_ALL || cur.term == T_RA);
        wb.ACK_I = (cur.term == T_ACK || cur.term == T_ALL || cur.term == T_RA);
        wb.DAT_I = cur.dat;
        wb.TGD_I = cur.tgd;
      end
      wcnt++;
    end else begin
      if (wb.CYC_O) gap_cnt++;
      // stray terminations while no strobe is out must be ignored
      if ($urandom_range(0, 3) == 0) begin
        wb.ACK_I = 1'($urandom_range(0, 1));
        wb.ERR_I = 1'($urandom_range(0, 1));
        wb.RTY_I = 1'($urandom_range(0, 1));
      end
    end
    prev_stb = wb.STB_O;
  end

  // Outcome of one command given the queued slave behaviour.
  function automatic void model(output int st, output int stb, output int att, output int rtr,
                                output logic [63:0] dat, output logic [15:0] tgd);
    att_t e;
    st = 0; stb = 0; att = 0; rtr = 0; dat = '0; tgd = '0;
    for (int i = 0; i <= MAX_RETRY; i++) begin
      if (i < script.size()) e = script[i];
      else                   e = '{0, T_SIL, 64'd0, 16'd0};
      att++;
      if (e.term == T_SIL || e.waits >= TIMEOUT) begin
        stb += TIMEOUT; st = 3; break;
      end
      stb += e.waits + 1;
      if (e.term == T_ERR || e.term == T_ALL) begin
        st = 1; break;
      end
      if (e.term == T_RTY || e.term == T_RA) begin
        if (rtr == MAX_RETRY) begin
          st = 2; break;
        end
        rtr++;
        continue;
      end
      st = 0; dat = e.dat; tgd = e.tgd; break;
    end
  endfunction

  task automatic push_att(input int waits, input int term, input logic [63:0] dat,
                          input logic [15:0] tgd);
    script.push_back('{waits, term, dat, tgd});
  endtask

  task automatic recover();
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    script.delete();
  endtask

  task automatic do_cmd(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                        input logic [7:0] sel, input logic [15:0] tga, input logic [15:0] tgc,
                        input logic [15:0] tgd, input logic lock, input int rdelay);
    int st, stb, att, rtr, lat;
    logic [63:0] edat;
    logic [15:0] etgd;
    bit got;
    model(st, stb, att, rtr, edat, etgd);
    e_we = we; e_adr = adr; e_dat = dat; e_sel = sel;
    e_tga = tga; e_tgc = tgc; e_tgd = tgd; e_lock = lock;
    @(negedge clk);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_tga = tga; cmd_tgc = tgc; cmd_tgd = tgd; cmd_lock = lock;
    cmd_valid = 1'b1;
    rsp_ready = (rdelay == 0);
    got = 0;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) begin got = 1; break; end
      @(negedge clk);
    end
    chk("accept", 64'(got), 64'd1);
    if (!got) begin recover(); return; end
    @(posedge clk);
    #1;
    stb_cnt = 0; att_cnt = 0; gap_cnt = 0; bus_bad = 0;
    chk("ready_low", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_adr = {$urandom, $urandom}; cmd_dat = {$urandom, $urandom};
    cmd_sel = 8'($urandom); cmd_tgd = 16'($urandom); cmd_we = ~we; cmd_lock = ~lock;
    lat = 0; got = 0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) begin got = 1; break; end
    end
    chk("rsp_seen", 64'(got), 64'd1);
    if (!got) begin recover(); return; end
    chk("latency", 64'(lat), 64'(stb + rtr));
    chk("status", 64'(rsp_status), 64'(st));
    chk("rsp_dat", rsp_dat, (we || st != 0) ? 64'd0 : edat);
    if (st == 0) chk("rsp_tgd", 64'(rsp_tgd), 64'(etgd));
    chk("stb_cycles", 64'(stb_cnt), 64'(stb));
    chk("attempts", 64'(att_cnt), 64'(att));
    chk("cyc_gap", 64'(gap_cnt), lock ? 64'(rtr) : 64'd0);
    chk("bus_fields", 64'(bus_bad), 64'd0);
    chk("bus_idle", 64'(wb.CYC_O), 64'd0);
    if (rdelay > 0) begin
      repeat (rdelay) begin
        @(posedge clk);
        #1;
      end
      chk("rsp_hold", {rsp_valid, 1'b0, rsp_status, rsp_dat[59:0]},
          {1'b1, 1'b0, 2'(st), ((we || st != 0) ? 60'd0 : edat[59:0])});
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rsp_done", {rsp_valid, cmd_ready}, 64'b01);
    script.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int term, waits, r;
    bit rv;
    wb.ACK_I = 1'b0; wb.ERR_I = 1'b0; wb.RTY_I = 1'b0;
    wb.DAT_I = '0;   wb.TGD_I = '0;
    e_we = 0; e_lock = 0; e_adr = '0; e_dat = '0; e_sel = '0; e_tga = '0; e_tgc = '0; e_tgd = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {cmd_ready, rsp_valid, wb.CYC_O, wb.STB_O, wb.LOCK_O, wb.WE_O, rsp_status},
        64'd0);
    chk("rst_bus", wb.ADR_O | wb.DAT_O | 64'(wb.SEL_O) | 64'(wb.TGD_O) | rsp_dat, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    cur_case = "zero_wait_write";
    push_att(0, T_ACK, 64'h1111_2222_3333_4444, 16'h1234);
    do_cmd(1'b1, 64'h1000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 16'h0001, 16'h0002, 16'h0003, 1'b0, 0);

    cur_case = "read_3_waits";
    push_att(3, T_ACK, 64'h0123_4567_89AB_CDEF, 16'h5A5A);
    do_cmd(1'b0, 64'h2000, 64'h0, 8'h0F, 16'h0011, 16'h0022, 16'h0033, 1'b0, 2);

    cur_case = "rty2_ack";
    push_att(0, T_RTY, 0, 0); push_att(1, T_RTY, 0, 0); push_att(0, T_ACK, 64'hA5A5, 16'h77);
    do_cmd(1'b0, 64'h3000, 64'h0, 8'hFF, 16'h1, 16'h2, 16'h3, 1'b0, 0);

    cur_case = "rty2_ack_locked";
    push_att(0, T_RTY, 0, 0); push_att(0, T_RTY, 0, 0); push_att(2, T_ACK, 64'h5A5A, 16'h88);
    do_cmd(1'b0, 64'h3008, 64'h0, 8'hF0, 16'h4, 16'h5, 16'h6, 1'b1, 1);

    cur_case = "rty_exhausted";
    for (int i = 0; i <= MAX_RETRY; i++) push_att(i, T_RTY, 0, 0);
    do_cmd(1'b1, 64'h4000, 64'h1234, 8'h3C, 16'h7, 16'h8, 16'h9, 1'b0, 0);

    cur_case = "err_rty_ack_together";
    push_att(0, T_ALL, 64'hFFFF, 16'hFFFF);
    do_cmd(1'b0, 64'h4100, 64'h0, 8'hFF, 16'hA, 16'hB, 16'hC, 1'b0, 0);

    cur_case = "ack_on_last_wait";
    push_att(TIMEOUT - 1, T_ACK, 64'hCAFE_0000_0000_BEEF, 16'hBEEF);
    do_cmd(1'b0, 64'h4200, 64'h0, 8'h01, 16'hD, 16'hE, 16'hF, 1'b0, 0);

    cur_case = "silent_timeout";
    do_cmd(1'b0, 64'h5000, 64'h0, 8'hFF, 16'h10, 16'h11, 16'h12, 1'b1, 0);

    cur_case = "reset_mid_bus";
    @(negedge clk);
    cmd_we = 1'b1; cmd_adr = 64'h6000; cmd_lock = 1'b0; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_rst", 64'(wb.CYC_O), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abandon", {wb.CYC_O, wb.STB_O, rsp_valid, cmd_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_mid_rst", 64'(cmd_ready), 64'd1);
    rv = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rsp_valid || wb.CYC_O) rv = 1;
    end
    chk("no_stale_rsp", 64'(rv), 64'd0);

    for (int n = 0; n < 60; n++) begin
      cur_case = $sformatf("random_%0d", n);
      for (int i = 0; i <= MAX_RETRY; i++) begin
        r = $urandom_range(0, 99);
        term = (r < 40) ? T_ACK : (r < 70) ? T_RTY : (r < 80) ? T_ERR :
               (r < 85) ? T_ALL : (r < 90) ? T_RA : T_SIL;
        waits = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT)
                                            : $urandom_range(0, 3);
        push_att(waits, term, {$urandom, $urandom}, 16'($urandom));
      end
      do_cmd(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
             8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
